// File: rtl/tile_scroller_pkg.sv
// Shared constants, FSM encoding and key helpers for the tile scroller game.
// Geometry is in pixels; each key row is KEY_HEIGHT tall and the bottom row spans BOTTOM_MIN..HEIGHT-1.
package tile_scroller_pkg;

  localparam logic [9:0]  HEIGHT     = 10'd120;
  localparam logic [9:0]  KEY_HEIGHT = 10'd30;
  localparam logic [8:0]  BOTTOM_MIN = 9'd90;
  localparam logic [9:0]  SCORE_MAX  = 10'd999;
  localparam int          KEY_W      = 4;
  localparam logic [19:0] KEYS_RESET = 20'h12481;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    DRAW,
    RELEASE,
    OVER
  } state_t;

  function automatic logic [KEY_W-1:0] key_onehot(input logic [1:0] sel);
    key_onehot      = '0;
    key_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/tile_scroller_key_lfsr.sv
// Pseudo-random source for new top-row keys: 8-bit Fibonacci LFSR (taps 8,6,5,4).
// The key output reflects the current state; step advances it by one.
module key_lfsr
  import tile_scroller_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             step,
  output logic [KEY_W-1:0] key
);

  logic [7:0] lfsr;
  logic       feedback;

  assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign key      = key_onehot(lfsr[1:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {lfsr[6:0], feedback};
    end
  end

endmodule

// File: rtl/tile_scroller.sv
// Piano-tiles style game core: scrolls five key rows, judges button presses and
// hands each frame to an external renderer through a draw_en/render_done handshake.
module tile_scroller
  import tile_scroller_pkg::*;
#(
  parameter logic [8:0] SPEED     = 9'd1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic [3:0]  play_keys,
  input  logic        render_done,
  output logic        draw_en,
  output logic [19:0] keys,
  output logic [8:0]  yoffset,
  output logic [1:0]  num_hit,
  output logic [9:0]  score,
  output logic        game_over
);

  state_t state, state_nxt;

  logic             pending_tick;
  logic             take_tick;
  logic [3:0]       prev_keys;
  logic [3:0]       rise;
  logic [3:0]       press_pend;

  logic [KEY_W-1:0] new_key;
  logic [KEY_W-1:0] target;
  logic             shift;
  logic             lfsr_step;
  logic [9:0]       sum;
  logic [19:0]      keys_nxt;
  logic [8:0]       y_nxt;
  logic [1:0]       hit_nxt;
  logic [9:0]       score_nxt;
  logic             over_nxt;

  key_lfsr #(
    .SEED (LFSR_SEED)
  ) u_key_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .step   (lfsr_step),
    .key    (new_key)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RELEASE returns to OVER once the game has ended so that OVER only replays the last frame.
  always_comb begin
    state_nxt = state;
    draw_en   = 1'b0;
    take_tick = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick || pending_tick) begin
          state_nxt = UPDATE;
          take_tick = 1'b1;
        end
      end
      UPDATE: begin
        state_nxt = over_nxt ? OVER : DRAW;
      end
      DRAW: begin
        draw_en = 1'b1;
        if (render_done) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = game_over ? OVER : IDLE;
      end
      OVER: begin
        if (frame_tick || pending_tick) begin
          state_nxt = DRAW;
          take_tick = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_tick <= 1'b0;
    end else if (take_tick) begin
      pending_tick <= 1'b0;
    end else if (frame_tick && (state == UPDATE || state == DRAW || state == RELEASE)) begin
      pending_tick <= 1'b1;
    end
  end

  assign rise = play_keys & ~prev_keys;

  // The whole edge vector is latched so multi-button presses are judged as wrong.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_keys  <= '0;
      press_pend <= '0;
    end else begin
      prev_keys <= play_keys;
      if (state == UPDATE && press_pend != '0) begin
        press_pend <= '0;
      end else if (press_pend == '0 && rise != '0) begin
        press_pend <= rise;
      end
    end
  end

  // Press judgement first, then scroll; the scroll sees the post-press hit count.
  always_comb begin
    target    = (num_hit == 2'd0) ? keys[KEY_W-1:0] : keys[2*KEY_W-1:KEY_W];
    hit_nxt   = num_hit;
    score_nxt = score;
    over_nxt  = game_over;
    keys_nxt  = keys;
    y_nxt     = yoffset;
    shift     = 1'b0;
    sum       = {1'b0, yoffset} + {1'b0, SPEED};

    if (press_pend != '0) begin
      if (num_hit < 2'd2 && press_pend == target) begin
        hit_nxt = num_hit + 2'd1;
        if (score < SCORE_MAX) begin
          score_nxt = score + 10'd1;
        end
      end else begin
        over_nxt = 1'b1;
      end
    end

    if (sum < HEIGHT) begin
      y_nxt = sum[8:0];
    end else begin
      shift    = 1'b1;
      y_nxt    = 9'(sum - KEY_HEIGHT);
      keys_nxt = {new_key, keys[19:KEY_W]};
      if (hit_nxt == 2'd0) begin
        over_nxt = 1'b1;
      end else begin
        hit_nxt = hit_nxt - 2'd1;
      end
    end
  end

  assign lfsr_step = shift && (state == UPDATE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keys      <= KEYS_RESET;
      yoffset   <= BOTTOM_MIN;
      num_hit   <= 2'd0;
      score     <= 10'd0;
      game_over <= 1'b0;
    end else if (state == UPDATE) begin
      keys      <= keys_nxt;
      yoffset   <= y_nxt;
      num_hit   <= hit_nxt;
      score     <= score_nxt;
      game_over <= over_nxt;
    end
  end

endmodule

// File: tb/tb_tile_scroller.sv
// Directed bench for tile_scroller: a SPEED=1 instance for frame/press/scroll behaviour
// and a SPEED=29 instance driven by a small game model to reach score saturation.
module tb_tile_scroller;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_tick;
  logic [3:0]  play_keys;
  logic        render_done;
  logic        draw_en;
  logic [19:0] keys;
  logic [8:0]  yoffset;
  logic [1:0]  num_hit;
  logic [9:0]  score;
  logic        game_over;

  logic        tick2;
  logic [3:0]  pk2;
  logic        done2;
  logic        de2;
  logic [19:0] keys2;
  logic [8:0]  y2;
  logic [1:0]  nh2;
  logic [9:0]  sc2;
  logic        go2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tile_scroller #(
    .SPEED     (9'd1),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .play_keys   (play_keys),
    .render_done (render_done),
    .draw_en     (draw_en),
    .keys        (keys),
    .yoffset     (yoffset),
    .num_hit     (num_hit),
    .score       (score),
    .game_over   (game_over)
  );

  tile_scroller #(
    .SPEED     (9'd29),
    .LFSR_SEED (8'hA5)
  ) dut_fast (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (tick2),
    .play_keys   (pk2),
    .render_done (done2),
    .draw_en     (de2),
    .keys        (keys2),
    .yoffset     (y2),
    .num_hit     (nh2),
    .score       (sc2),
    .game_over   (go2)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk) play_keys = k;
    @(negedge clk) play_keys = 4'd0;
  endtask

  task automatic wait_draw(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (draw_en) break;
      @(negedge clk);
    end
    check_output(tag, 32'(draw_en), 32'd1);
  endtask

  task automatic end_draw(input string tag);
    render_done = 1'b1;
    @(negedge clk);
    render_done = 1'b0;
    check_output(tag, 32'(draw_en), 32'd0);
  endtask

  task automatic run_frame();
    pulse_tick();
    wait_draw("frame draw_en");
    end_draw("frame release");
  endtask

  task automatic run_fast_frame(input logic [3:0] k, output bit ok);
    ok = 1'b1;
    if (k != 4'd0) begin
      @(negedge clk) pk2 = k;
      @(negedge clk) pk2 = 4'd0;
    end
    @(negedge clk) tick2 = 1'b1;
    @(negedge clk) tick2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (de2) break;
      @(negedge clk);
    end
    if (!de2) begin
      ok = 1'b0;
      check_output("fast draw_en", 32'(de2), 32'd1);
    end else begin
      done2 = 1'b1;
      @(negedge clk);
      done2 = 1'b0;
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          gap;
    bit          seen_high;
    bit          ok;
    logic [19:0] mk;
    logic [7:0]  ml;
    logic [9:0]  my;
    logic [9:0]  msum;
    int          mh;
    int          ms;
    logic [3:0]  mp;

    resetn      = 1'b0;
    frame_tick  = 1'b0;
    play_keys   = 4'd0;
    render_done = 1'b0;
    tick2       = 1'b0;
    pk2         = 4'd0;
    done2       = 1'b0;

    do_reset();
    check_output("reset keys", 32'(keys), 32'h12481);
    check_output("reset yoffset", 32'(yoffset), 32'd90);
    check_output("reset num_hit", 32'(num_hit), 32'd0);
    check_output("reset score", 32'(score), 32'd0);
    check_output("reset game_over", 32'(game_over), 32'd0);
    check_output("reset draw_en", 32'(draw_en), 32'd0);

    // One frame: single UPDATE cycle, draw held until render_done.
    pulse_tick();
    check_output("update draw_en low", 32'(draw_en), 32'd0);
    check_output("update yoffset old", 32'(yoffset), 32'd90);
    @(negedge clk);
    check_output("draw_en rises", 32'(draw_en), 32'd1);
    check_output("yoffset +1", 32'(yoffset), 32'd91);
    repeat (3) @(negedge clk);
    check_output("draw_en held", 32'(draw_en), 32'd1);
    end_draw("release low");
    @(negedge clk);
    check_output("idle low", 32'(draw_en), 32'd0);

    // Correct presses on bottom (bit0) then second row (bit3), the second together with the tick.
    press(4'b0001);
    run_frame();
    check_output("hit1 num_hit", 32'(num_hit), 32'd1);
    check_output("hit1 score", 32'(score), 32'd1);
    @(negedge clk);
    play_keys  = 4'b1000;
    frame_tick = 1'b1;
    @(negedge clk);
    play_keys  = 4'd0;
    frame_tick = 1'b0;
    wait_draw("hit2 draw_en");
    end_draw("hit2 release");
    check_output("hit2 num_hit", 32'(num_hit), 32'd2);
    check_output("hit2 score", 32'(score), 32'd2);
    press(4'b0001);
    pulse_tick();
    repeat (3) @(negedge clk);
    check_output("third press game_over", 32'(game_over), 32'd1);
    check_output("over no draw", 32'(draw_en), 32'd0);
    check_output("over score frozen", 32'(score), 32'd2);
    check_output("over yoffset", 32'(yoffset), 32'd94);
    pulse_tick();
    wait_draw("over tick draws");
    check_output("over draw score", 32'(score), 32'd2);
    end_draw("over release");

    // Missed bottom key at the shift boundary.
    do_reset();
    repeat (29) run_frame();
    check_output("miss yoffset 119", 32'(yoffset), 32'd119);
    pulse_tick();
    repeat (2) @(negedge clk);
    check_output("miss game_over", 32'(game_over), 32'd1);
    check_output("miss draw_en low", 32'(draw_en), 32'd0);
    check_output("miss yoffset", 32'(yoffset), 32'd90);
    check_output("miss keys", 32'(keys), 32'h21248);
    check_output("miss score", 32'(score), 32'd0);
    pulse_tick();
    wait_draw("miss over draws");
    end_draw("miss over release");
    check_output("miss sticky", 32'(game_over), 32'd1);

    // Hit at y=119, then a clean shift.
    do_reset();
    repeat (28) run_frame();
    press(4'b0001);
    run_frame();
    check_output("pre-shift yoffset", 32'(yoffset), 32'd119);
    check_output("pre-shift num_hit", 32'(num_hit), 32'd1);
    run_frame();
    check_output("shift yoffset", 32'(yoffset), 32'd90);
    check_output("shift keys", 32'(keys), 32'h21248);
    check_output("shift num_hit", 32'(num_hit), 32'd0);
    check_output("shift game_over", 32'(game_over), 32'd0);
    check_output("shift score", 32'(score), 32'd1);

    // Press and two ticks during DRAW: state frozen, exactly one extra UPDATE.
    pulse_tick();
    wait_draw("busy draw_en");
    @(negedge clk) play_keys = 4'b1000;
    @(negedge clk) play_keys = 4'd0;
    frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check_output("busy keys", 32'(keys), 32'h21248);
    check_output("busy num_hit", 32'(num_hit), 32'd0);
    check_output("busy score", 32'(score), 32'd1);
    check_output("busy yoffset", 32'(yoffset), 32'd91);
    check_output("busy draw_en", 32'(draw_en), 32'd1);
    end_draw("busy release");
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      if (draw_en) break;
      gap++;
      @(negedge clk);
    end
    check_output("pending gap", 32'(gap), 32'd3);
    check_output("pending num_hit", 32'(num_hit), 32'd1);
    check_output("pending score", 32'(score), 32'd2);
    check_output("pending yoffset", 32'(yoffset), 32'd92);
    end_draw("pending release");
    seen_high = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (draw_en) seen_high = 1'b1;
    end
    check_output("no extra update", 32'(seen_high), 32'd0);
    check_output("no extra yoffset", 32'(yoffset), 32'd92);
    repeat (27) run_frame();
    run_frame();
    check_output("shift2 keys", 32'(keys), 32'h42124);
    check_output("shift2 yoffset", 32'(yoffset), 32'd90);
    check_output("shift2 num_hit", 32'(num_hit), 32'd0);
    check_output("shift2 game_over", 32'(game_over), 32'd0);

    // Reset while drawing drops draw_en without a clock edge.
    pulse_tick();
    wait_draw("pre-reset draw_en");
    #2 resetn = 1'b0;
    #1;
    check_output("async draw_en", 32'(draw_en), 32'd0);
    check_output("async yoffset", 32'(yoffset), 32'd90);
    check_output("async keys", 32'(keys), 32'h12481);
    @(negedge clk) resetn = 1'b1;
    run_frame();
    check_output("post-reset yoffset", 32'(yoffset), 32'd91);

    // Fast instance: play perfectly until the score saturates.
    do_reset();
    mk = 20'h12481;
    ml = 8'hA5;
    my = 10'd90;
    mh = 0;
    ms = 0;
    ok = 1'b1;
    for (int f = 0; f < 1200 && ms < 1000 && ok; f++) begin
      mp = (mh == 0) ? mk[3:0] : (mh == 1) ? mk[7:4] : 4'd0;
      run_fast_frame(mp, ok);
      if (mp != 4'd0) begin
        mh++;
        if (ms < 999) ms++;
      end
      msum = my + 10'd29;
      if (msum < 10'd120) begin
        my = msum;
      end else begin
        my = msum - 10'd30;
        mk = {4'b0001 << ml[1:0], mk[19:4]};
        ml = lfsr_next(ml);
        mh--;
      end
      if (ms == 999) begin
        check_output("sat reach score", 32'(sc2), 32'd999);
        check_output("sat reach keys", 32'(keys2), 32'(mk));
        check_output("sat reach yoffset", 32'(y2), 32'(my));
        mp = (mh == 0) ? mk[3:0] : mk[7:4];
        run_fast_frame(mp, ok);
        mh++;
        msum = my + 10'd29;
        if (msum < 10'd120) begin
          my = msum;
        end else begin
          my = msum - 10'd30;
          mk = {4'b0001 << ml[1:0], mk[19:4]};
          ml = lfsr_next(ml);
          mh--;
        end
        check_output("sat hold score", 32'(sc2), 32'd999);
        check_output("sat num_hit", 32'(nh2), 32'(mh));
        check_output("sat game_over", 32'(go2), 32'd0);
        check_output("sat keys", 32'(keys2), 32'(mk));
        ms = 1000;
      end
    end
    check_output("sat reached", 32'(ms), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
